// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache with multi-beat line refill and round-robin replacement.
// Latency: hit responds 1 cycle after accept; miss responds 1 cycle after the last refill beat.
// Backpressure: req_ready is high only in IDLE; refill beats are accepted without stalling.
module icache_set_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kill,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_data,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int WW   = $clog2(LINE_WORDS);
  localparam int OFF  = WW + 2;
  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAGW = ADDR_WIDTH - OFF - IDX;
  localparam int WAYW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MISS_REQ, S_REFILL, S_RESPOND} state_t;

  state_t r_state, w_state_nxt;

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [WAYW-1:0]     r_rr    [NUM_SETS];
  logic [TAGW-1:0]     r_tag   [NUM_SETS][NUM_WAYS];
  logic [31:0]         r_data  [NUM_SETS][NUM_WAYS][LINE_WORDS];

  logic [ADDR_WIDTH-1:2] r_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WW-1:0]         r_beat;
  logic [WAYW-1:0]       r_victim;
  logic                  r_victim_rr;
  logic                  r_killed;
  logic                  r_flushed;
  logic [31:0]           r_fill_word;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_data;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_miss_count;

  // Byte-within-word bits are not needed: the response is always the aligned word.
  logic w_unused;
  assign w_unused = ^req_addr[1:0];

  logic [IDX-1:0]  w_req_idx, w_idx;
  logic [TAGW-1:0] w_req_tag, w_tag;
  logic [WW-1:0]   w_req_word, w_word;
  assign w_req_idx  = req_addr[OFF+IDX-1:OFF];
  assign w_req_tag  = req_addr[ADDR_WIDTH-1:OFF+IDX];
  assign w_req_word = req_addr[OFF-1:2];
  assign w_idx      = r_addr[OFF+IDX-1:OFF];
  assign w_tag      = r_addr[ADDR_WIDTH-1:OFF+IDX];
  assign w_word     = r_addr[OFF-1:2];

  logic            w_hit;
  logic [WAYW-1:0] w_hit_way;
  logic [31:0]     w_hit_data;
  logic [WAYW-1:0] w_vic_way;
  logic            w_vic_rr;

  // Tag compare of the incoming request against every way of its set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (r_valid[w_req_idx][w] && (r_tag[w_req_idx][w] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
    end
  end
  assign w_hit_data = r_data[w_req_idx][w_hit_way][w_req_word];

  // Victim choice: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    w_vic_way = r_rr[w_idx];
    w_vic_rr  = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_vic_way = WAYW'(w);
        w_vic_rr  = 1'b0;
      end
    end
  end

  logic w_accept, w_last_beat, w_respond, w_install;
  assign w_accept    = (r_state == S_IDLE) && req_valid && !kill && !flush;
  assign w_last_beat = (r_state == S_REFILL) && mem_valid && (r_beat == WW'(LINE_WORDS - 1));
  assign w_respond   = !(kill || flush || r_killed);
  // A flush anywhere in the miss window means the line may be stale: never install it.
  assign w_install   = w_last_beat && !flush && !r_flushed;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept && !w_hit) w_state_nxt = S_MISS_REQ;
      end
      S_MISS_REQ: begin
        mem_req     = 1'b1;
        w_state_nxt = S_REFILL;
      end
      S_REFILL: begin
        if (w_last_beat) w_state_nxt = w_respond ? S_RESPOND : S_IDLE;
      end
      S_RESPOND: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, refill bookkeeping, response register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_mem_addr   <= '0;
      r_beat       <= '0;
      r_victim     <= '0;
      r_victim_rr  <= 1'b0;
      r_killed     <= 1'b0;
      r_flushed    <= 1'b0;
      r_fill_word  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= req_addr[ADDR_WIDTH-1:2];
        if (w_hit) begin
          r_resp_valid <= 1'b1;
          r_resp_data  <= w_hit_data;
          if (r_hit_count != 32'hffff_ffff) r_hit_count <= r_hit_count + 32'd1;
        end else begin
          r_mem_addr <= {req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          r_killed   <= 1'b0;
          r_flushed  <= 1'b0;
          if (r_miss_count != 32'hffff_ffff) r_miss_count <= r_miss_count + 32'd1;
        end
      end
      if (r_state == S_MISS_REQ) begin
        r_beat      <= '0;
        r_victim    <= w_vic_way;
        r_victim_rr <= w_vic_rr;
      end
      if ((r_state == S_MISS_REQ) || (r_state == S_REFILL)) begin
        if (kill || flush) r_killed  <= 1'b1;
        if (flush)         r_flushed <= 1'b1;
      end
      if ((r_state == S_REFILL) && mem_valid) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == w_word) r_fill_word <= mem_data;
      end
      // The requested word may be the final beat, which is not yet in r_fill_word
      if (w_last_beat && w_respond) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= (w_word == WW'(LINE_WORDS - 1)) ? mem_data : r_fill_word;
      end
    end
  end

  // Valid bits and round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) r_valid[s] <= '0;
    end else if (w_install) begin
      r_valid[w_idx][r_victim] <= 1'b1;
      if (r_victim_rr && (NUM_WAYS > 1)) r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
    end
  end

  // Line data and tags; contents are qualified by the valid bits so need no reset
  always_ff @(posedge clk) begin
    if ((r_state == S_REFILL) && mem_valid) r_data[w_idx][r_victim][r_beat] <= mem_data;
    if (w_install) r_tag[w_idx][r_victim] <= w_tag;
  end

  assign resp_valid = r_resp_valid && !kill && !flush;
  assign resp_data  = r_resp_data;
  assign mem_addr   = r_mem_addr;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: fills, hits, replacement, kill, flush, async reset.
// Inputs change and outputs are sampled on the falling clock edge.
// Memory model returns line beats base+k in ascending order, one per cycle.
module tb_icache_set_assoc;

  logic        clk;
  logic        rst;
  logic        kill;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mreq_cnt = 0;

  icache_set_assoc dut (
    .clk        (clk),
    .rst        (rst),
    .kill       (kill),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req) mreq_cnt <= mreq_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, want);
    end
  endtask

  // Single hit: request on one falling edge, response visible on the next
  task automatic do_hit(input string tag, input logic [31:0] addr, input logic [31:0] want);
    int mc0;
    mc0 = mreq_cnt;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ":resp_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, ":resp_data"}, resp_data, want);
    @(negedge clk);
    check({tag, ":no_mem_req"}, mreq_cnt, mc0);
  endtask

  // Miss with full line refill; kill_at/flush_at pick the beat on which to pulse (-1 = never)
  task automatic do_miss(input string tag, input logic [31:0] addr, input logic [31:0] base,
                         input int kill_at, input int flush_at);
    int          mc0;
    logic [31:0] want;
    mc0  = mreq_cnt;
    want = base + {28'd0, addr[3:2]};
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ":mem_req"}, {31'd0, mem_req}, 32'd1);
    check({tag, ":mem_addr"}, mem_addr, {addr[31:4], 4'h0});
    check({tag, ":req_ready_busy"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1;
      mem_data  = base + k;
      kill      = (k == kill_at);
      flush     = (k == flush_at);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    kill      = 1'b0;
    flush     = 1'b0;
    if (kill_at < 0 && flush_at < 0) begin
      check({tag, ":resp_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, ":resp_data"}, resp_data, want);
    end else begin
      check({tag, ":resp_suppressed"}, {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    check({tag, ":req_ready_idle"}, {31'd0, req_ready}, 32'd1);
    check({tag, ":mem_req_once"}, mreq_cnt, mc0 + 1);
  endtask

  initial begin
    rst       = 1'b1;
    kill      = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst:req_ready", {31'd0, req_ready}, 32'd1);
    check("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst:resp_data", resp_data, 32'd0);
    check("rst:mem_req", {31'd0, mem_req}, 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:hits", hit_count, 32'd0);
    check("rst:misses", miss_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss
    do_miss("t1_cold", 32'h100, 32'hA0, -1, -1);
    check("t1:misses", miss_count, 32'd1);

    // Back-to-back hits in the same line
    req_valid = 1'b1;
    req_addr  = 32'h10C;
    @(negedge clk);
    check("t2a:resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t2a:resp_data", resp_data, 32'hA3);
    req_addr = 32'h106;
    @(negedge clk);
    req_valid = 1'b0;
    check("t2b:resp_valid", {31'd0, resp_valid}, 32'd1);
    check("t2b:resp_data", resp_data, 32'hA1);
    check("t2:mem_req", mreq_cnt, 1);
    check("t2:hits", hit_count, 32'd2);
    @(negedge clk);

    // Replacement in set 0: 0x300 evicts way 0 (0x100), then 0x100 evicts 0x200
    do_miss("t3_200", 32'h200, 32'hB0, -1, -1);
    do_miss("t3_300", 32'h300, 32'hC0, -1, -1);
    do_hit("t3_hit200", 32'h208, 32'hB2);
    do_miss("t3_re100", 32'h104, 32'h50, -1, -1);
    check("t3:misses", miss_count, 32'd4);

    // Kill mid-refill: no response, but the line is installed
    do_miss("t4_kill400", 32'h400, 32'hD0, 2, -1);
    do_hit("t4_hit400", 32'h40C, 32'hD3);
    do_hit("t4_hit100", 32'h100, 32'h50);

    // Kill in the request cycle: request ignored
    req_valid = 1'b1;
    req_addr  = 32'h100;
    kill      = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    kill      = 1'b0;
    check("kreq:resp_valid", {31'd0, resp_valid}, 32'd0);
    check("kreq:hits", hit_count, 32'd5);

    // Kill in the response cycle of a hit: response suppressed
    req_valid = 1'b1;
    req_addr  = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    kill      = 1'b1;
    #1;
    check("kresp:resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    check("kresp:hits", hit_count, 32'd6);

    // Flush mid-refill: nothing installed, everything invalid
    do_miss("t5_flush500", 32'h500, 32'hE0, -1, 1);
    do_miss("t5_miss100", 32'h100, 32'h60, -1, -1);
    do_miss("t5_miss500", 32'h50C, 32'hE0, -1, -1);
    do_hit("t5_hit500", 32'h504, 32'hE1);
    check("t5:hits", hit_count, 32'd7);
    check("t5:misses", miss_count, 32'd8);

    // Asynchronous reset in the middle of a refill
    req_valid = 1'b1;
    req_addr  = 32'h600;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_data  = 32'h90;
    @(negedge clk);
    mem_data  = 32'h91;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6:req_ready", {31'd0, req_ready}, 32'd1);
    check("t6:resp_valid", {31'd0, resp_valid}, 32'd0);
    check("t6:resp_data", resp_data, 32'd0);
    check("t6:mem_req", {31'd0, mem_req}, 32'd0);
    check("t6:mem_addr", mem_addr, 32'd0);
    check("t6:hits", hit_count, 32'd0);
    check("t6:misses", miss_count, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_miss("t6_miss500", 32'h500, 32'h70, -1, -1);
    check("t6:misses_after", miss_count, 32'd1);
    check("t6:hits_after", hit_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
